// File: rtl/program_loader.sv
// Byte-stream boot loader: address, word count and 16-bit words from a host, written to instruction memory.
// Optional trailing XOR checksum byte (CHECK state) is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned BOOT_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        write_enable_fm,
    output logic [31:0] write_addr_fm,
    output logic [15:0] write_data_fm,
    output logic        core_rst,
    output logic        done,
    output logic        error
);
    typedef enum logic [3:0] {
        IDLE, ADDR, COUNT, DATA_LO, DATA_HI, CHECK, HOLD, DONE, ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHECK;
`else
    localparam state_t AFTER_DATA = HOLD;
`endif

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_lo_q, cnt_lo_d;
    logic [15:0] words_q, words_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] data_q, data_d;
    logic        we_q, we_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] hold_q, hold_d;

    logic        accept;
    logic        start_ok;
    logic [15:0] count_n;

    assign accept   = in_valid && in_ready;
    assign start_ok = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign count_n  = {in_data, cnt_lo_q};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            cnt_lo_q   <= '0;
            words_q    <= '0;
            lo_q       <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            csum_q     <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            cnt_lo_q   <= cnt_lo_d;
            words_q    <= words_d;
            lo_q       <= lo_d;
            data_q     <= data_d;
            we_q       <= we_d;
            csum_q     <= csum_d;
            hold_q     <= hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start_ok) state_d = ADDR;
            ADDR:    if (accept && byte_cnt_q == 2'd3) state_d = COUNT;
            COUNT: begin
                if (accept && byte_cnt_q == 2'd1) begin
                    if ({16'd0, count_n} > 32'(MAX_WORDS)) state_d = ERR;
                    else if (count_n == 16'd0)             state_d = AFTER_DATA;
                    else                                   state_d = DATA_LO;
                end
            end
            DATA_LO: if (accept) state_d = DATA_HI;
            DATA_HI: if (accept) state_d = (words_q == 16'd1) ? AFTER_DATA : DATA_LO;
`ifdef LOADER_CHECKSUM_EN
            CHECK:   if (accept) state_d = (in_data == csum_q) ? HOLD : ERR;
`endif
            HOLD:    if (hold_q == 32'(BOOT_HOLD - 1)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: byte assembly, checksum, write strobe and address advance
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        cnt_lo_d   = cnt_lo_q;
        words_d    = words_q;
        lo_d       = lo_q;
        data_d     = data_q;
        we_d       = 1'b0;
        csum_d     = csum_q;
        hold_d     = (state_q == HOLD) ? hold_q + 32'd1 : '0;

        if (start_ok) begin
            byte_cnt_d = '0;
            csum_d     = '0;
        end
        if (we_q) addr_d = addr_q + 32'd1;

        if (accept) begin
            if (state_q != CHECK) csum_d = csum_q ^ in_data;
            case (state_q)
                ADDR: begin
                    addr_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
                COUNT: begin
                    if (byte_cnt_q == 2'd0) begin
                        cnt_lo_d   = in_data;
                        byte_cnt_d = 2'd1;
                    end else begin
                        words_d    = count_n;
                        byte_cnt_d = 2'd0;
                    end
                end
                DATA_LO: lo_d = in_data;
                DATA_HI: begin
                    data_d  = {in_data, lo_q};
                    we_d    = 1'b1;
                    words_d = words_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        in_ready        = (state_q == ADDR) || (state_q == COUNT) || (state_q == DATA_LO) ||
                          (state_q == DATA_HI) || (state_q == CHECK);
        write_enable_fm = we_q;
        write_addr_fm   = addr_q;
        write_data_fm   = data_q;
        core_rst        = (state_q != DONE);
        done            = (state_q == DONE);
        error           = (state_q == ERR);
    end
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized loads against a stream-level model.
// Builds with or without LOADER_CHECKSUM_EN.
module tb_program_loader;
    localparam int unsigned MAX_WORDS = 1024;
    localparam int unsigned BOOT_HOLD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        write_enable_fm;
    logic [31:0] write_addr_fm;
    logic [15:0] write_data_fm;
    logic        core_rst;
    logic        done;
    logic        error;

    program_loader #(.MAX_WORDS(MAX_WORDS), .BOOT_HOLD(BOOT_HOLD)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .write_enable_fm(write_enable_fm), .write_addr_fm(write_addr_fm),
        .write_data_fm(write_data_fm), .core_rst(core_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [15:0] data; int unsigned cyc; } wr_t;

    wr_t         wr_q[$];
    int unsigned acc_cyc[$];
    logic [7:0]  stim[$];
    logic [31:0] exp_addr[$];
    logic [15:0] exp_data[$];
    int unsigned exp_hi[$];
    bit          exp_err;
    int unsigned exp_last;
    int unsigned cyc = 0;
    int unsigned fall_cyc = 0;
    bit          fell = 0;
    logic        prev_core_rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (write_enable_fm === 1'b1) wr_q.push_back('{write_addr_fm, write_data_fm, cyc});
        if (prev_core_rst === 1'b1 && core_rst === 1'b0) begin
            fell = 1;
            fall_cyc = cyc;
        end
        prev_core_rst = core_rst;
    end

    // Reference: interpret the byte stream directly
    task automatic model_load();
        int unsigned n;
        logic [31:0] a;
        logic [7:0]  x;
        exp_addr.delete(); exp_data.delete(); exp_hi.delete();
        a = {stim[3], stim[2], stim[1], stim[0]};
        n = {16'd0, stim[5], stim[4]};
        exp_err = 0;
        exp_last = 5;
        if (n > MAX_WORDS) begin
            exp_err = 1;
            return;
        end
        for (int unsigned i = 0; i < n; i++) begin
            exp_addr.push_back(a + i);
            exp_data.push_back({stim[7 + 2*i], stim[6 + 2*i]});
            exp_hi.push_back(7 + 2*i);
        end
        exp_last = 5 + 2*n;
`ifdef LOADER_CHECKSUM_EN
        x = '0;
        for (int unsigned i = 0; i <= exp_last; i++) x = x ^ stim[i];
        exp_last = exp_last + 1;
        exp_err = (stim[exp_last] !== x);
`endif
    endtask

    // Enter and leave at a negedge; ok=0 if the byte was never accepted
    task automatic send_byte(input logic [7:0] b, input int unsigned gap_pct, output bit ok);
        int unsigned t;
        t = 0;
        ok = 0;
        while (gap_pct != 0 && t < 8 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            @(negedge clk);
            t++;
        end
        in_valid = 1'b1;
        in_data = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 32) begin
            @(negedge clk);
            t++;
        end
        if (in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            acc_cyc.push_back(cyc);
            ok = 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_load(input int unsigned gap_pct, output bit to);
        bit ok;
        int unsigned t;
        to = 0;
        wr_q.delete(); acc_cyc.delete(); fell = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int unsigned i = 0; i <= exp_last; i++) begin
            send_byte(stim[i], gap_pct, ok);
            if (!ok) begin
                to = 1;
                break;
            end
        end
        t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (done !== 1'b1 && error !== 1'b1) to = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset.in_ready got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (write_enable_fm !== 1'b0) $display("FAIL reset.we got %b exp 0", write_enable_fm); else n_pass++;
        n_checks++; if ({write_addr_fm, write_data_fm} !== 48'd0) $display("FAIL reset.addr_data got %h exp 0", {write_addr_fm, write_data_fm}); else n_pass++;
        n_checks++; if ({core_rst, done, error} !== 3'b100) $display("FAIL reset.flags got %b exp 100", {core_rst, done, error}); else n_pass++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if ({in_ready, core_rst, done, error} !== 4'b0100) $display("FAIL reset.idle got %b exp 0100", {in_ready, core_rst, done, error}); else n_pass++;
    endtask

    task automatic build_good(input logic [7:0] last);
        stim = {8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(last);
`else
        if (last == 8'h00) stim.push_back(last);
`endif
    endtask

    task automatic test_good_load();
        bit to;
        build_good(8'h52);
        model_load();
        do_load(0, to);
        n_checks++; if (to) $display("FAIL good.timeout got 1 exp 0"); else n_pass++;
        n_checks++; if (wr_q.size() !== 2) $display("FAIL good.nwrites got %0d exp 2", wr_q.size()); else n_pass++;
        if (wr_q.size() == 2) begin
            n_checks++; if (wr_q[0].addr !== 32'h10 || wr_q[0].data !== 16'h1234) $display("FAIL good.w0 got %h/%h exp 00000010/1234", wr_q[0].addr, wr_q[0].data); else n_pass++;
            n_checks++; if (wr_q[1].addr !== 32'h11 || wr_q[1].data !== 16'hABCD) $display("FAIL good.w1 got %h/%h exp 00000011/abcd", wr_q[1].addr, wr_q[1].data); else n_pass++;
            n_checks++; if (wr_q[0].cyc !== acc_cyc[7] || wr_q[1].cyc !== acc_cyc[9]) $display("FAIL good.wr_timing got %0d,%0d exp %0d,%0d", wr_q[0].cyc, wr_q[1].cyc, acc_cyc[7], acc_cyc[9]); else n_pass++;
        end
        n_checks++; if (!fell || fall_cyc - acc_cyc[exp_last] !== BOOT_HOLD) $display("FAIL good.hold got fell=%0d delay=%0d exp %0d", fell, fall_cyc - acc_cyc[exp_last], BOOT_HOLD); else n_pass++;
        n_checks++; if ({core_rst, done, error, in_ready} !== 4'b0100) $display("FAIL good.flags got %b exp 0100", {core_rst, done, error, in_ready}); else n_pass++;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        bit to;
        build_good(8'h53);
        model_load();
        do_load(0, to);
        n_checks++; if (to) $display("FAIL badsum.timeout got 1 exp 0"); else n_pass++;
        n_checks++; if (wr_q.size() !== 2) $display("FAIL badsum.nwrites got %0d exp 2", wr_q.size()); else n_pass++;
        n_checks++; if ({core_rst, done, error} !== 3'b101) $display("FAIL badsum.flags got %b exp 101", {core_rst, done, error}); else n_pass++;
    endtask
`endif

    task automatic test_zero_count();
        bit to;
        stim = {8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12);
`endif
        model_load();
        do_load(0, to);
        n_checks++; if (to) $display("FAIL zero.timeout got 1 exp 0"); else n_pass++;
        n_checks++; if (wr_q.size() !== 0) $display("FAIL zero.nwrites got %0d exp 0", wr_q.size()); else n_pass++;
        n_checks++; if ({core_rst, done, error} !== 3'b010) $display("FAIL zero.flags got %b exp 010", {core_rst, done, error}); else n_pass++;
    endtask

    task automatic test_overflow();
        bit to;
        int unsigned ready_seen;
        stim = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h04, 8'h11, 8'h22};
        model_load();
        do_load(0, to);
        n_checks++; if (to) $display("FAIL ovf.timeout got 1 exp 0"); else n_pass++;
        n_checks++; if ({core_rst, done, error} !== 3'b101) $display("FAIL ovf.flags got %b exp 101", {core_rst, done, error}); else n_pass++;
        ready_seen = 0;
        in_valid = 1'b1;
        in_data = 8'h11;
        repeat (10) begin
            @(negedge clk);
            if (in_ready !== 1'b0) ready_seen++;
        end
        in_valid = 1'b0;
        n_checks++; if (ready_seen !== 0) $display("FAIL ovf.in_ready got %0d ready cycles exp 0", ready_seen); else n_pass++;
        n_checks++; if (wr_q.size() !== 0) $display("FAIL ovf.nwrites got %0d exp 0", wr_q.size()); else n_pass++;
    endtask

    task automatic test_max_count();
        bit to;
        int unsigned bad;
        stim = {8'h00, 8'h01, 8'h00, 8'h00, 8'(MAX_WORDS), 8'(MAX_WORDS >> 8)};
        for (int unsigned i = 0; i < 2*MAX_WORDS; i++) stim.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h00);
        model_load();
        stim[exp_last] = exp_err ? 8'h00 ^ 8'h00 : 8'h00;
        begin
            logic [7:0] x;
            x = '0;
            for (int unsigned i = 0; i < exp_last; i++) x = x ^ stim[i];
            stim[exp_last] = x;
        end
`endif
        model_load();
        do_load(0, to);
        n_checks++; if (to) $display("FAIL max.timeout got 1 exp 0"); else n_pass++;
        n_checks++; if (wr_q.size() !== MAX_WORDS) $display("FAIL max.nwrites got %0d exp %0d", wr_q.size(), MAX_WORDS); else n_pass++;
        bad = 0;
        for (int unsigned i = 0; i < wr_q.size() && i < exp_addr.size(); i++)
            if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i]) bad++;
        n_checks++; if (bad !== 0) $display("FAIL max.data got %0d bad words exp 0", bad); else n_pass++;
        n_checks++; if ({done, error} !== 2'b10) $display("FAIL max.flags got %b exp 10", {done, error}); else n_pass++;
    endtask

    task automatic test_wrap_stall();
        bit to;
        stim = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h02 ^ 8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4);
`endif
        model_load();
        do_load(60, to);
        n_checks++; if (to) $display("FAIL wrap.timeout got 1 exp 0"); else n_pass++;
        n_checks++; if (wr_q.size() !== 2) $display("FAIL wrap.nwrites got %0d exp 2", wr_q.size()); else n_pass++;
        if (wr_q.size() == 2) begin
            n_checks++; if (wr_q[0].addr !== 32'hFFFF_FFFF || wr_q[0].data !== 16'hB2A1) $display("FAIL wrap.w0 got %h/%h exp ffffffff/b2a1", wr_q[0].addr, wr_q[0].data); else n_pass++;
            n_checks++; if (wr_q[1].addr !== 32'h0 || wr_q[1].data !== 16'hD4C3) $display("FAIL wrap.w1 got %h/%h exp 00000000/d4c3", wr_q[1].addr, wr_q[1].data); else n_pass++;
        end
        n_checks++; if ({done, error} !== 2'b10) $display("FAIL wrap.flags got %b exp 10", {done, error}); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        bit ok, to;
        int unsigned ready_seen;
        wr_q.delete(); acc_cyc.delete();
        stim = {8'h20, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int unsigned i = 0; i < 9; i++) send_byte(stim[i], 0, ok);
        in_valid = 1'b1;
        in_data = 8'h44;
        reset = 1'b0;
        #1;
        n_checks++; if ({in_ready, write_enable_fm, core_rst, done, error} !== 5'b00100) $display("FAIL midrst.flags got %b exp 00100", {in_ready, write_enable_fm, core_rst, done, error}); else n_pass++;
        n_checks++; if ({write_addr_fm, write_data_fm} !== 48'd0) $display("FAIL midrst.addr_data got %h exp 0", {write_addr_fm, write_data_fm}); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        ready_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (in_ready !== 1'b0) ready_seen++;
        end
        in_valid = 1'b0;
        n_checks++; if (ready_seen !== 0) $display("FAIL midrst.no_start got %0d ready cycles exp 0", ready_seen); else n_pass++;
        n_checks++; if (wr_q.size() !== 1 || wr_q[0].addr !== 32'h20 || wr_q[0].data !== 16'h2211) $display("FAIL midrst.writes got %0d writes exp 1 at 00000020/2211", wr_q.size()); else n_pass++;
        build_good(8'h52);
        model_load();
        do_load(0, to);
        n_checks++; if (to || wr_q.size() !== 2 || done !== 1'b1) $display("FAIL midrst.reload got to=%0d n=%0d done=%b exp 0/2/1", to, wr_q.size(), done); else n_pass++;
    endtask

    task automatic test_random_loads();
        bit to;
        int unsigned n, bad;
        logic [31:0] a;
        logic [7:0]  x;
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(6, 0);
            a = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE : $urandom;
            stim = {a[7:0], a[15:8], a[23:16], a[31:24], 8'(n), 8'h00};
            for (int unsigned i = 0; i < 2*n; i++) stim.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
            x = '0;
            foreach (stim[i]) x = x ^ stim[i];
            if ($urandom_range(3) == 0) x = x ^ (8'h01 << $urandom_range(7));
            stim.push_back(x);
`else
            x = '0;
`endif
            model_load();
            do_load($urandom_range(60), to);
            bad = 0;
            if (wr_q.size() != exp_addr.size()) bad++;
            for (int unsigned i = 0; i < wr_q.size() && i < exp_addr.size(); i++)
                if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i] || wr_q[i].cyc !== acc_cyc[exp_hi[i]]) bad++;
            n_checks++; if (to || bad != 0) $display("FAIL rand%0d.writes got to=%0d bad=%0d n=%0d exp n=%0d", k, to, bad, wr_q.size(), exp_addr.size()); else n_pass++;
            n_checks++; if ({core_rst, done, error} !== {exp_err, !exp_err, exp_err}) $display("FAIL rand%0d.flags got %b exp %b", k, {core_rst, done, error}, {exp_err, !exp_err, exp_err}); else n_pass++;
            if (!exp_err) begin
                n_checks++; if (!fell || fall_cyc - acc_cyc[exp_last] !== BOOT_HOLD) $display("FAIL rand%0d.hold got delay %0d exp %0d", k, fall_cyc - acc_cyc[exp_last], BOOT_HOLD); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_zero_count();
        test_overflow();
        test_max_count();
        test_wrap_stall();
        test_reset_mid_load();
        test_random_loads();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
